keypad_scan: RTL and testbench

Matrix keypad scanner for the board's 4x4 key matrix, the input-side counterpart of the dot-matrix row-scan display driver. It drives one row low at a time and samples the column lines. It then debounces a press and reports a single key code with a one-cycle valid strobe. It runs on the same 1 kHz scan clock as the display logic and feeds the digit/state control logic.

---
 rtl/keypad_scan.sv | 191 +++++++++++++++++++
 tb/tb_keypad_scan.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan.sv
// keypad_scan: row-scanning driver and debouncer for a ROWS x COLS key matrix.
// Drives one row low at a time, samples the (synchronized) column lines and
// reports a debounced press as a key code plus a one-cycle valid strobe.
// Optional feature macro: KEY_REPEAT_EN (auto-repeat strobes while a key is held).
module keypad_scan #(
  parameter int ROWS          = 4,
  parameter int COLS          = 4,
  parameter int SETTLE        = 4,
  parameter int DEBOUNCE      = 20,
  parameter int REPEAT_DELAY  = 500,
  parameter int REPEAT_PERIOD = 100
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [COLS-1:0] col_in,
  output logic [ROWS-1:0] row_out,
  output logic [3:0]      key_code,
  output logic            key_valid,
  output logic            key_down
);

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_PRESS_DB = 2'd1;
  localparam logic [1:0] ST_HOLD     = 2'd2;
  localparam logic [1:0] ST_REL_DB   = 2'd3;

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  // One counter width shared by the dwell, debounce and repeat timers.
  localparam int MAX_A   = (SETTLE > DEBOUNCE) ? SETTLE : DEBOUNCE;
  localparam int MAX_B   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE - 1);
`ifdef KEY_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] REP_PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
`endif

  logic [COLS-1:0]  col_meta;
  logic [COLS-1:0]  col_s;
  logic [1:0]       state;
  logic [RW-1:0]    row_idx;
  logic [RW-1:0]    row_nxt;
  logic [ROWS-1:0]  row_nxt_drive;
  logic [CNT_W-1:0] dwell_cnt;
  logic [CNT_W-1:0] db_cnt;
  logic [CW-1:0]    cand_col;
  logic             cand_bit;
`ifdef KEY_REPEAT_EN
  logic [CNT_W-1:0] rep_cnt;
  logic             rep_first;
`endif

  // Lowest-index column reading 0 (closed); lower columns win ties.
  function automatic logic [CW-1:0] lowest_zero(input logic [COLS-1:0] c);
    logic [CW-1:0] idx;
    idx = '0;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (!c[i]) idx = CW'(i);
    end
    return idx;
  endfunction

  // Key code is row * COLS + col.
  function automatic logic [3:0] make_code(input logic [RW-1:0] r, input logic [CW-1:0] c);
    return 4'(int'(r) * COLS + int'(c));
  endfunction

  // Next row in scan order and its active-low one-hot drive pattern.
  always_comb begin
    row_nxt       = (row_idx == RW'(ROWS - 1)) ? '0 : row_idx + 1'b1;
    row_nxt_drive = ~(ROWS'(1) << row_nxt);
  end

  assign cand_bit = col_s[cand_col];

  // Two-flop synchronizer on the asynchronous column lines (idle = all 1s).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta <= '1;
      col_s    <= '1;
    end else begin
      col_meta <= col_in;
      col_s    <= col_meta;
    end
  end

  // Scan / debounce / hold state machine with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_SCAN;
      row_idx   <= '0;
      row_out   <= ~ROWS'(1);
      dwell_cnt <= '0;
      db_cnt    <= '0;
      cand_col  <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
`ifdef KEY_REPEAT_EN
      rep_cnt   <= '0;
      rep_first <= 1'b1;
`endif
    end else begin
      key_valid <= 1'b0;
      case (state)
        ST_SCAN: begin
          if (dwell_cnt == SETTLE_LAST) begin
            dwell_cnt <= '0;
            if (col_s != '1) begin
              // Row stays driven while the candidate is debounced.
              cand_col <= lowest_zero(col_s);
              db_cnt   <= '0;
              state    <= ST_PRESS_DB;
            end else begin
              row_idx <= row_nxt;
              row_out <= row_nxt_drive;
            end
          end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
          end
        end
        ST_PRESS_DB: begin
          if (cand_bit) begin
            db_cnt  <= '0;
            state   <= ST_SCAN;
            row_idx <= row_nxt;
            row_out <= row_nxt_drive;
          end else if (db_cnt == DB_LAST) begin
            db_cnt    <= '0;
            key_code  <= make_code(row_idx, cand_col);
            key_valid <= 1'b1;
            key_down  <= 1'b1;
            state     <= ST_HOLD;
`ifdef KEY_REPEAT_EN
            rep_cnt   <= '0;
            rep_first <= 1'b1;
`endif
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        ST_HOLD: begin
          if (cand_bit) begin
            db_cnt <= '0;
            state  <= ST_REL_DB;
`ifdef KEY_REPEAT_EN
            rep_cnt   <= '0;
            rep_first <= 1'b1;
`endif
          end
`ifdef KEY_REPEAT_EN
          else if (rep_cnt == (rep_first ? REP_DELAY_LAST : REP_PERIOD_LAST)) begin
            // First repeat after the long delay, then at the shorter period.
            rep_cnt   <= '0;
            rep_first <= 1'b0;
            key_valid <= 1'b1;
          end else begin
            rep_cnt <= rep_cnt + 1'b1;
          end
`endif
        end
        ST_REL_DB: begin
          if (!cand_bit) begin
            // Key closed again: back to HOLD without a new strobe.
            db_cnt <= '0;
            state  <= ST_HOLD;
`ifdef KEY_REPEAT_EN
            rep_cnt   <= '0;
            rep_first <= 1'b1;
`endif
          end else if (db_cnt == DB_LAST) begin
            db_cnt   <= '0;
            key_down <= 1'b0;
            state    <= ST_SCAN;
            row_idx  <= row_nxt;
            row_out  <= row_nxt_drive;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        default: state <= ST_SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed bench for keypad_scan with a behavioural 4x4 key matrix.
module tb_keypad_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_down;
  logic [15:0] pressed;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int strobe_cnt  = 0;
  int strobe_cyc  = 0;
  int dbl_cnt     = 0;
  logic [3:0] strobe_code = 4'd0;
  logic       prev_valid  = 1'b0;
  int strobe_q[$];

  keypad_scan #(
    .ROWS(4), .COLS(4), .SETTLE(4), .DEBOUNCE(20),
    .REPEAT_DELAY(50), .REPEAT_PERIOD(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .col_in(col_in), .row_out(row_out),
    .key_code(key_code), .key_valid(key_valid), .key_down(key_down)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Key matrix: a closed key pulls its column low while its row is driven.
  always_comb begin
    col_in = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_out[r] && pressed[r*4+c]) col_in[c] = 1'b0;
  end

  // Strobe recorder, sampled on the falling edge.
  always @(negedge clk) begin
    if (key_valid) begin
      strobe_cnt  <= strobe_cnt + 1;
      strobe_cyc  <= cyc;
      strobe_code <= key_code;
      strobe_q.push_back(cyc);
      if (prev_valid) dbl_cnt <= dbl_cnt + 1;
    end
    prev_valid <= key_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_strobe(input int base, input int limit, output bit got);
    got = 1'b0;
    for (int i = 0; i < limit && !got; i++) begin
      tick();
      if (strobe_cnt > base) got = 1'b1;
    end
  endtask

  // Strobes expected after acceptance at edge a, as seen just after edge now.
  function automatic int exp_strobes(input int a, input int now);
`ifdef KEY_REPEAT_EN
    int held;
    held = now - 1 - a;
    if (held >= 50) return 2 + (held - 50) / 10;
`endif
    return 1;
  endfunction

  task automatic test_reset();
    #1;
    vectors++; if (row_out !== 4'b1110) begin miscompares++; $display("FAIL rst_row_out: got %b want 1110", row_out); end
    vectors++; if (key_code !== 4'd0) begin miscompares++; $display("FAIL rst_key_code: got %0d want 0", key_code); end
    vectors++; if (key_valid !== 1'b0) begin miscompares++; $display("FAIL rst_key_valid: got %b want 0", key_valid); end
    vectors++; if (key_down !== 1'b0) begin miscompares++; $display("FAIL rst_key_down: got %b want 0", key_down); end
    tick(); tick();
    rst_n = 1'b1;
    repeat (3) tick();
    vectors++; if (row_out !== 4'b1110) begin miscompares++; $display("FAIL scan_row0_dwell: got %b want 1110", row_out); end
    tick();
    vectors++; if (row_out !== 4'b1101) begin miscompares++; $display("FAIL scan_row1: got %b want 1101", row_out); end
    repeat (4) tick();
    vectors++; if (row_out !== 4'b1011) begin miscompares++; $display("FAIL scan_row2: got %b want 1011", row_out); end
  endtask

  task automatic test_single_press();
    int base, c0, a, lat;
    bit got;
    base = strobe_cnt;
    c0 = cyc;
    pressed[9] = 1'b1;
    wait_strobe(base, 60, got);
    vectors++; if (!got) begin miscompares++; $display("FAIL single_strobe: got none want 1 within 60 cycles"); end
    vectors++; if (strobe_code !== 4'd9) begin miscompares++; $display("FAIL single_code: got %0d want 9", strobe_code); end
    lat = strobe_cyc - c0;
    vectors++; if (lat > 39) begin miscompares++; $display("FAIL single_latency: got %0d want <=39", lat); end
    a = strobe_cyc;
    while (cyc < c0 + 100) tick();
    vectors++; if (strobe_cnt - base !== exp_strobes(a, cyc)) begin miscompares++; $display("FAIL single_count: got %0d want %0d", strobe_cnt - base, exp_strobes(a, cyc)); end
    vectors++; if (key_down !== 1'b1) begin miscompares++; $display("FAIL single_down_held: got %b want 1", key_down); end
    pressed = '0;
    repeat (20) tick();
    vectors++; if (key_down !== 1'b1) begin miscompares++; $display("FAIL single_down_rel20: got %b want 1", key_down); end
    repeat (6) tick();
    vectors++; if (key_down !== 1'b0) begin miscompares++; $display("FAIL single_down_rel26: got %b want 0", key_down); end
    vectors++; if (key_code !== 4'd9) begin miscompares++; $display("FAIL single_code_kept: got %0d want 9", key_code); end
    repeat (20) tick();
  endtask

  task automatic test_bouncy_press();
    int base;
    bit got;
    base = strobe_cnt;
    for (int ph = 0; ph < 6; ph++) begin
      pressed[3] = (ph % 2 == 0);
      repeat (5) tick();
    end
    vectors++; if (strobe_cnt !== base) begin miscompares++; $display("FAIL bounce_no_strobe: got %0d want 0", strobe_cnt - base); end
    pressed[3] = 1'b1;
    wait_strobe(base, 60, got);
    vectors++; if (!got) begin miscompares++; $display("FAIL bounce_strobe: got none want 1 within 60 cycles"); end
    vectors++; if (strobe_code !== 4'd3) begin miscompares++; $display("FAIL bounce_code: got %0d want 3", strobe_code); end
    repeat (30) tick();
    vectors++; if (strobe_cnt - base !== 1) begin miscompares++; $display("FAIL bounce_count: got %0d want 1", strobe_cnt - base); end
    pressed = '0;
    repeat (40) tick();
  endtask

  task automatic test_multi_key();
    int base, a;
    bit got;
    base = strobe_cnt;
    pressed[4] = 1'b1;
    pressed[7] = 1'b1;
    wait_strobe(base, 60, got);
    vectors++; if (!got) begin miscompares++; $display("FAIL multi_strobe: got none want 1 within 60 cycles"); end
    vectors++; if (strobe_code !== 4'd4) begin miscompares++; $display("FAIL multi_code: got %0d want 4", strobe_code); end
    a = strobe_cyc;
    pressed[2] = 1'b1;
    repeat (60) tick();
    vectors++; if (strobe_cnt - base !== exp_strobes(a, cyc)) begin miscompares++; $display("FAIL multi_count: got %0d want %0d", strobe_cnt - base, exp_strobes(a, cyc)); end
    vectors++; if (key_code !== 4'd4) begin miscompares++; $display("FAIL multi_code_kept: got %0d want 4", key_code); end
    vectors++; if (key_down !== 1'b1) begin miscompares++; $display("FAIL multi_down: got %b want 1", key_down); end
    pressed = '0;
    repeat (40) tick();
    vectors++; if (key_down !== 1'b0) begin miscompares++; $display("FAIL multi_released: got %b want 0", key_down); end
  endtask

  task automatic test_release_bounce();
    int base;
    bit got, down_ok;
    base = strobe_cnt;
    pressed[5] = 1'b1;
    wait_strobe(base, 60, got);
    vectors++; if (!got) begin miscompares++; $display("FAIL relb_strobe: got none want 1 within 60 cycles"); end
    down_ok = 1'b1;
    for (int ph = 0; ph < 5; ph++) begin
      pressed[5] = (ph % 2 == 1);
      for (int i = 0; i < 8; i++) begin
        tick();
        if (key_down !== 1'b1) down_ok = 1'b0;
      end
    end
    vectors++; if (!down_ok) begin miscompares++; $display("FAIL relb_down_during_bounce: got 0 want 1"); end
    repeat (30) tick();
    vectors++; if (key_down !== 1'b0) begin miscompares++; $display("FAIL relb_down_after: got %b want 0", key_down); end
    vectors++; if (strobe_cnt - base !== 1) begin miscompares++; $display("FAIL relb_count: got %0d want 1", strobe_cnt - base); end
    repeat (10) tick();
  endtask

  task automatic test_reset_in_hold();
    int base;
    bit got;
    base = strobe_cnt;
    pressed[15] = 1'b1;
    wait_strobe(base, 60, got);
    vectors++; if (!got) begin miscompares++; $display("FAIL rsth_first_strobe: got none want 1 within 60 cycles"); end
    vectors++; if (strobe_code !== 4'd15) begin miscompares++; $display("FAIL rsth_first_code: got %0d want 15", strobe_code); end
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    vectors++; if (row_out !== 4'b1110) begin miscompares++; $display("FAIL rsth_row_out: got %b want 1110", row_out); end
    vectors++; if (key_code !== 4'd0) begin miscompares++; $display("FAIL rsth_key_code: got %0d want 0", key_code); end
    vectors++; if (key_down !== 1'b0) begin miscompares++; $display("FAIL rsth_key_down: got %b want 0", key_down); end
    repeat (3) tick();
    rst_n = 1'b1;
    base = strobe_cnt;
    wait_strobe(base, 60, got);
    vectors++; if (!got) begin miscompares++; $display("FAIL rsth_new_strobe: got none want 1 within 60 cycles"); end
    vectors++; if (strobe_code !== 4'd15) begin miscompares++; $display("FAIL rsth_new_code: got %0d want 15", strobe_code); end
    pressed = '0;
    repeat (40) tick();
  endtask

  task automatic test_repeat();
    int base, a;
    bit got;
    strobe_q.delete();
    base = strobe_cnt;
    pressed[6] = 1'b1;
    wait_strobe(base, 60, got);
    vectors++; if (!got) begin miscompares++; $display("FAIL rep_strobe: got none want 1 within 60 cycles"); end
    vectors++; if (strobe_code !== 4'd6) begin miscompares++; $display("FAIL rep_code: got %0d want 6", strobe_code); end
    a = strobe_cyc;
    for (int i = 0; i < 200 && cyc < a + 101; i++) tick();
    pressed = '0;
    repeat (40) tick();
`ifdef KEY_REPEAT_EN
    vectors++; if (strobe_q.size() !== 7) begin miscompares++; $display("FAIL rep_count: got %0d want 7", strobe_q.size()); end
    for (int k = 1; k < 7 && k < strobe_q.size(); k++) begin
      vectors++;
      if (strobe_q[k] - a !== 40 + 10 * k) begin
        miscompares++;
        $display("FAIL rep_offset_%0d: got %0d want %0d", k, strobe_q[k] - a, 40 + 10 * k);
      end
    end
`else
    vectors++; if (strobe_q.size() !== 1) begin miscompares++; $display("FAIL rep_count: got %0d want 1", strobe_q.size()); end
`endif
  endtask

  initial begin
    rst_n   = 1'b1;
    pressed = '0;
    #1 rst_n = 1'b0;
    test_reset();
    test_single_press();
    test_bouncy_press();
    test_multi_key();
    test_release_bounce();
    test_reset_in_hold();
    test_repeat();
    vectors++; if (dbl_cnt !== 0) begin miscompares++; $display("FAIL valid_back_to_back: got %0d want 0", dbl_cnt); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
